// File: rtl/amount_to_dig.sv
`default_nettype none
// ============================================================================
//  Module      : amount_to_dig
//  Description : Converts a 10-bit binary amount into three packed 5-bit
//                seven-segment digit codes using an iterative shift-add-3
//                (double-dabble) engine with a start/busy/done handshake.
//                Leading zeros can be blanked and amounts above 999 are
//                shown as three dashes. The last result is held between
//                conversions.
//  Revision    : 1.0 - initial release
// ============================================================================
module amount_to_dig #(
    parameter bit         BLANK_LZ   = 1'b1,
    parameter logic [4:0] CODE_BLANK = 5'd16,
    parameter logic [4:0] CODE_DASH  = 5'd17
) (
    input  logic        clk100MHZ,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  value,
    output logic        busy,
    output logic        done,
    output logic [14:0] dig
);

    localparam logic [3:0] c_LAST_ITER = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      r_state;
    logic [9:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;
    logic [14:0] r_dig;

    logic [11:0] w_bcd_adj;
    logic [14:0] w_dig_next;
    logic        w_unused_carry;

    // Add-3 correction on every BCD nibble, all judged on the pre-add value
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                    ? r_bcd[gi*4 +: 4] + 4'd3
                                    : r_bcd[gi*4 +: 4];
    end

    // The bit shifted out of the hundreds nibble only occurs for values
    // above 999, which are already reported through the overflow path.
    assign w_unused_carry = w_bcd_adj[11];

    // Build the display word from the finished BCD result
    always_comb begin
        w_dig_next = {CODE_DASH, CODE_DASH, CODE_DASH};
        if (!r_ovf) begin
            w_dig_next = {1'b0, r_bcd[11:8], 1'b0, r_bcd[7:4], 1'b0, r_bcd[3:0]};
            if (BLANK_LZ) begin
                if (r_bcd[11:8] == 4'd0) begin
                    w_dig_next[14:10] = CODE_BLANK;
                end
                if (r_bcd[11:4] == 8'd0) begin
                    w_dig_next[9:5] = CODE_BLANK;
                end
            end
        end
    end

    // Conversion sequencer: capture, ten shift-add-3 steps, then publish
    always_ff @(posedge clk100MHZ) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bin   <= 10'd0;
            r_bcd   <= 12'd0;
            r_cnt   <= 4'd0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dig   <= {CODE_BLANK, CODE_BLANK, 5'd0};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin   <= value;
                        r_bcd   <= 12'd0;
                        r_cnt   <= 4'd0;
                        r_ovf   <= (value > 10'd999);
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= {w_bcd_adj[10:0], r_bin[9]};
                    r_bin <= {r_bin[8:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_dig   <= w_dig_next;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dig  = r_dig;

endmodule
`default_nettype wire
